// File: rtl/gru_ctrl_pkg.sv
// Shared definitions for the GRU timestep sequencer: FSM states, gate codes,
// activation-select codes and small width helpers.
package gru_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BIAS    = 3'd1,
    S_MAC_IN  = 3'd2,
    S_MAC_REC = 3'd3,
    S_ACT     = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6
  } gru_state_e;

  localparam logic [1:0] GATE_Z = 2'd0;
  localparam logic [1:0] GATE_R = 2'd1;
  localparam logic [1:0] GATE_H = 2'd2;

  localparam logic [1:0] ACT_SIGMOID = 2'd0;
  localparam logic [1:0] ACT_TANH    = 2'd1;
  localparam logic [1:0] ACT_RELU    = 2'd2;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [1:0] act_code(input logic [1:0] gate, input int act_h);
    if (gate != GATE_H) return ACT_SIGMOID;
    return (act_h != 0) ? ACT_RELU : ACT_TANH;
  endfunction

endpackage

// File: rtl/gru_sequencer_addr_gen.sv
// Combinational address generator: bias and weight addresses from gate, j, k.
// Weight memory is k-major with a row stride of 3*N_UNITS.
module gru_addr_gen
  import gru_ctrl_pkg::*;
#(
  parameter int N_UNITS = 24,
  parameter int K_MAX   = 24,
  localparam int UW = idx_w(N_UNITS),
  localparam int KW = idx_w(K_MAX),
  localparam int BW = idx_w(3 * N_UNITS),
  localparam int WW = idx_w(3 * N_UNITS * K_MAX)
) (
  input  logic [1:0]    gate,
  input  logic [UW-1:0] unit_idx,
  input  logic [KW-1:0] k_idx,
  output logic [BW-1:0] bias_addr,
  output logic [WW-1:0] w_addr
);

  localparam int STRIDE = 3 * N_UNITS;

  logic [WW-1:0] gate_off;

  always_comb begin
    gate_off  = WW'(gate) * WW'(N_UNITS) + WW'(unit_idx);
    bias_addr = BW'(gate_off);
    w_addr    = WW'(k_idx) * WW'(STRIDE) + gate_off;
  end

endmodule

// File: rtl/gru_sequencer.sv
// GRU timestep sequencer: walks gates z, r, h over all units, driving bias load,
// input/recurrent MAC sweeps, an activation handshake and buffer/state writes.
module gru_sequencer
  import gru_ctrl_pkg::*;
#(
  parameter int M_IN    = 24,
  parameter int N_UNITS = 24,
  parameter int ACT_H   = 0,
  localparam int K_MAX  = (M_IN > N_UNITS) ? M_IN : N_UNITS,
  localparam int UW     = idx_w(N_UNITS),
  localparam int KW     = idx_w(K_MAX),
  localparam int BW     = idx_w(3 * N_UNITS),
  localparam int WW     = idx_w(3 * N_UNITS * K_MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [1:0]    gate,
  output logic [UW-1:0] unit_idx,
  output logic [KW-1:0] k_idx,
  output logic [BW-1:0] bias_addr,
  output logic [WW-1:0] w_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_src,
  output logic          rgate_mul,
  output logic          act_req,
  input  logic          act_ack,
  output logic [1:0]    act_sel,
  output logic          gate_we,
  output logic          state_we,
  output gru_state_e    state_dbg
);

  // Handshake: act_req rises on entry to ACT and stays high until a cycle in
  // which act_ack is sampled high at the rising edge; that edge moves to WRITE.
  // act_ack is ignored outside ACT, and abort takes priority over it.

  localparam logic [KW-1:0] K_IN_LAST  = KW'(M_IN - 1);
  localparam logic [KW-1:0] K_REC_LAST = KW'(N_UNITS - 1);
  localparam logic [UW-1:0] J_LAST     = UW'(N_UNITS - 1);

  gru_state_e    state;
  gru_state_e    nxt_state;
  logic [1:0]    nxt_gate;
  logic [UW-1:0] nxt_j;
  logic [KW-1:0] nxt_k;
  logic [BW-1:0] nxt_bias_addr;
  logic [WW-1:0] nxt_w_addr;

  always_comb begin
    nxt_state = state;
    nxt_gate  = gate;
    nxt_j     = unit_idx;
    nxt_k     = k_idx;
    if (abort && (state != S_IDLE)) begin
      nxt_state = S_IDLE;
      nxt_gate  = GATE_Z;
      nxt_j     = '0;
      nxt_k     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            nxt_state = S_BIAS;
            nxt_gate  = GATE_Z;
            nxt_j     = '0;
            nxt_k     = '0;
          end
        end
        S_BIAS: begin
          nxt_state = S_MAC_IN;
          nxt_k     = '0;
        end
        S_MAC_IN: begin
          if (k_idx == K_IN_LAST) begin
            nxt_state = S_MAC_REC;
            nxt_k     = '0;
          end else begin
            nxt_k = k_idx + KW'(1);
          end
        end
        S_MAC_REC: begin
          if (k_idx == K_REC_LAST) begin
            nxt_state = S_ACT;
            nxt_k     = '0;
          end else begin
            nxt_k = k_idx + KW'(1);
          end
        end
        S_ACT: begin
          if (act_ack) nxt_state = S_WRITE;
        end
        S_WRITE: begin
          // Finishing a gate's last unit moves to the next gate, so every r
          // value is written before the first h accumulation begins.
          if (unit_idx == J_LAST) begin
            nxt_j = '0;
            if (gate == GATE_H) begin
              nxt_state = S_DONE;
              nxt_gate  = GATE_Z;
            end else begin
              nxt_state = S_BIAS;
              nxt_gate  = gate + 2'd1;
            end
          end else begin
            nxt_state = S_BIAS;
            nxt_j     = unit_idx + UW'(1);
          end
        end
        S_DONE:  nxt_state = S_IDLE;
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  gru_addr_gen #(
    .N_UNITS (N_UNITS),
    .K_MAX   (K_MAX)
  ) u_addr_gen (
    .gate      (nxt_gate),
    .unit_idx  (nxt_j),
    .k_idx     (nxt_k),
    .bias_addr (nxt_bias_addr),
    .w_addr    (nxt_w_addr)
  );

  // Outputs are decoded from the next state so they land in the same cycle
  // as the state they describe, with addresses aligned to their strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gate      <= GATE_Z;
      unit_idx  <= '0;
      k_idx     <= '0;
      bias_addr <= '0;
      w_addr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      mac_src   <= 1'b0;
      rgate_mul <= 1'b0;
      act_req   <= 1'b0;
      act_sel   <= ACT_SIGMOID;
      gate_we   <= 1'b0;
      state_we  <= 1'b0;
    end else begin
      state     <= nxt_state;
      gate      <= nxt_gate;
      unit_idx  <= nxt_j;
      k_idx     <= nxt_k;
      bias_addr <= nxt_bias_addr;
      w_addr    <= nxt_w_addr;
      busy      <= (nxt_state != S_IDLE);
      done      <= (nxt_state == S_DONE);
      mac_clr   <= (nxt_state == S_BIAS);
      mac_en    <= (nxt_state == S_MAC_IN) || (nxt_state == S_MAC_REC);
      mac_src   <= (nxt_state == S_MAC_REC);
      rgate_mul <= (nxt_state == S_MAC_REC) && (nxt_gate == GATE_H);
      act_req   <= (nxt_state == S_ACT);
      act_sel   <= (nxt_state == S_ACT) ? act_code(nxt_gate, ACT_H) : ACT_SIGMOID;
      gate_we   <= (nxt_state == S_WRITE);
      state_we  <= (nxt_state == S_WRITE) && (nxt_gate == GATE_H);
    end
  end

  assign state_dbg = state;

  strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({mac_clr, mac_en, act_req, gate_we, done}));
  state_we_in_write: assert property (@(posedge clk) disable iff (!rst_n)
    state_we |-> gate_we);
  rgate_on_rec: assert property (@(posedge clk) disable iff (!rst_n)
    rgate_mul |-> mac_src);

endmodule

// File: tb/tb_gru_sequencer.sv
// Self-checking bench for gru_sequencer: two parameterisations, a per-cycle
// reference model derived from neuron/phase arithmetic, and a write scoreboard.
module tb_gru_sequencer;
  import gru_ctrl_pkg::*;

  localparam int MA = 24, NA = 24;
  localparam int MB = 90, NB = 48;
  localparam int UWA = idx_w(NA), KWA = idx_w(24), BWA = idx_w(3*NA), WWA = idx_w(3*NA*24);
  localparam int UWB = idx_w(NB), KWB = idx_w(90), BWB = idx_w(3*NB), WWB = idx_w(3*NB*90);
  localparam int SBW = 2 + UWA;

  typedef struct packed {
    logic [31:0] busy, done, gate, unit, k, baddr, waddr;
    logic [31:0] clr, en, src, rmul, req, sel, gwe, swe;
  } obs_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 24 x 24, tanh
  logic start_a = 1'b0, abort_a = 1'b0, act_ack_a = 1'b1;
  logic busy_a, done_a, mac_clr_a, mac_en_a, mac_src_a, rgate_mul_a, act_req_a, gate_we_a, state_we_a;
  logic [1:0] gate_a, act_sel_a;
  logic [UWA-1:0] unit_a;
  logic [KWA-1:0] k_a;
  logic [BWA-1:0] baddr_a;
  logic [WWA-1:0] waddr_a;
  gru_state_e dbg_a;

  // DUT B: 90 x 48, relu
  logic start_b = 1'b0, abort_b = 1'b0;
  logic act_ack_b;
  logic busy_b, done_b, mac_clr_b, mac_en_b, mac_src_b, rgate_mul_b, act_req_b, gate_we_b, state_we_b;
  logic [1:0] gate_b, act_sel_b;
  logic [UWB-1:0] unit_b;
  logic [KWB-1:0] k_b;
  logic [BWB-1:0] baddr_b;
  logic [WWB-1:0] waddr_b;
  gru_state_e dbg_b;
  assign act_ack_b = 1'b1;

  gru_sequencer #(.M_IN(MA), .N_UNITS(NA), .ACT_H(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .gate(gate_a), .unit_idx(unit_a), .k_idx(k_a),
    .bias_addr(baddr_a), .w_addr(waddr_a), .mac_clr(mac_clr_a), .mac_en(mac_en_a),
    .mac_src(mac_src_a), .rgate_mul(rgate_mul_a), .act_req(act_req_a), .act_ack(act_ack_a),
    .act_sel(act_sel_a), .gate_we(gate_we_a), .state_we(state_we_a), .state_dbg(dbg_a)
  );

  gru_sequencer #(.M_IN(MB), .N_UNITS(NB), .ACT_H(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .gate(gate_b), .unit_idx(unit_b), .k_idx(k_b),
    .bias_addr(baddr_b), .w_addr(waddr_b), .mac_clr(mac_clr_b), .mac_en(mac_en_b),
    .mac_src(mac_src_b), .rgate_mul(rgate_mul_b), .act_req(act_req_b), .act_ack(act_ack_b),
    .act_sel(act_sel_b), .gate_we(gate_we_b), .state_we(state_we_b), .state_dbg(dbg_b)
  );

  int vec_cnt = 0;
  int miscmp = 0;
  logic [SBW-1:0] exp_q[$];
  obs_t zero_o = '0;

  // Activation responder for DUT A: ack after ack_delay_a request cycles (0 = tied high).
  int ack_delay_a = 0;
  int ack_cnt = 0;
  always @(negedge clk) begin
    if (!act_req_a) ack_cnt = 0;
    else ack_cnt = ack_cnt + 1;
    act_ack_a = (ack_delay_a == 0) || (act_req_a && (ack_cnt >= ack_delay_a));
  end

  // Reference: cycle t after the start edge lies in neuron t/p at phase t%p,
  // where p = m + n + 2 + d (bias, m input MACs, n recurrent MACs, d ACT, write).
  function automatic obs_t model_at(int t, int m, int n, int act_h, int d);
    obs_t o;
    int p, nrn, ph;
    o = '0;
    p = m + n + 2 + d;
    if (t < 0 || t > 3*n*p) return o;
    o.busy = 32'd1;
    if (t == 3*n*p) begin
      o.done = 32'd1;
      return o;
    end
    nrn = t / p;
    ph  = t % p;
    o.gate  = 32'(nrn / n);
    o.unit  = 32'(nrn % n);
    if (ph == 0) o.clr = 32'd1;
    else if (ph <= m) begin
      o.en = 32'd1;
      o.k  = 32'(ph - 1);
    end else if (ph <= m + n) begin
      o.en   = 32'd1;
      o.src  = 32'd1;
      o.k    = 32'(ph - 1 - m);
      o.rmul = 32'(o.gate == 32'd2);
    end else if (ph < p - 1) begin
      o.req = 32'd1;
      o.sel = (o.gate == 32'd2) ? ((act_h != 0) ? 32'd2 : 32'd1) : 32'd0;
    end else begin
      o.gwe = 32'd1;
      o.swe = 32'(o.gate == 32'd2);
    end
    o.baddr = o.gate * 32'(n) + o.unit;
    o.waddr = o.k * 32'(3*n) + o.baddr;
    return o;
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o.busy = 32'(busy_a); o.done = 32'(done_a); o.gate = 32'(gate_a); o.unit = 32'(unit_a);
    o.k = 32'(k_a); o.baddr = 32'(baddr_a); o.waddr = 32'(waddr_a); o.clr = 32'(mac_clr_a);
    o.en = 32'(mac_en_a); o.src = 32'(mac_src_a); o.rmul = 32'(rgate_mul_a); o.req = 32'(act_req_a);
    o.sel = 32'(act_sel_a); o.gwe = 32'(gate_we_a); o.swe = 32'(state_we_a);
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.busy = 32'(busy_b); o.done = 32'(done_b); o.gate = 32'(gate_b); o.unit = 32'(unit_b);
    o.k = 32'(k_b); o.baddr = 32'(baddr_b); o.waddr = 32'(waddr_b); o.clr = 32'(mac_clr_b);
    o.en = 32'(mac_en_b); o.src = 32'(mac_src_b); o.rmul = 32'(rgate_mul_b); o.req = 32'(act_req_b);
    o.sel = 32'(act_sel_b); o.gwe = 32'(gate_we_b); o.swe = 32'(state_we_b);
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("busy=%0d done=%0d g=%0d j=%0d k=%0d ba=%0d wa=%0d clr=%0d en=%0d src=%0d rm=%0d req=%0d sel=%0d gwe=%0d swe=%0d",
      o.busy, o.done, o.gate, o.unit, o.k, o.baddr, o.waddr, o.clr, o.en, o.src, o.rmul, o.req, o.sel, o.gwe, o.swe);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    vec_cnt++;
    if (obs_a() !== zero_o) begin
      miscmp++; $display("FAIL reset_a got %s want all zero", fmt(obs_a()));
    end
    vec_cnt++;
    if (obs_b() !== zero_o) begin
      miscmp++; $display("FAIL reset_b got %s want all zero", fmt(obs_b()));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (obs_a() !== zero_o) begin
        miscmp++; $display("FAIL idle_after_reset got %s want all zero", fmt(obs_a()));
      end
    end
  endtask

  // One full timestep on DUT A with fixed ack delay d; optional start noise while busy.
  task automatic test_timestep(input int d, input bit noise, input string tag);
    int d_eff, p, tend, t_done, n_done, n_gwe, n_swe;
    obs_t got, want;
    logic [SBW-1:0] w;
    d_eff = (d == 0) ? 1 : d;
    p = MA + NA + 2 + d_eff;
    tend = 3*NA*p + 3;
    t_done = -1; n_done = 0; n_gwe = 0; n_swe = 0;
    exp_q.delete();
    for (int g = 0; g < 3; g++)
      for (int j = 0; j < NA; j++) exp_q.push_back(SBW'((g << UWA) | j));
    ack_delay_a = d;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= tend; t++) begin
      if (t > 0) @(negedge clk);
      start_a = noise && (t < 3*NA*p) && ($urandom_range(0, 5) == 0);
      got = obs_a();
      want = model_at(t, MA, NA, 0, d_eff);
      vec_cnt++;
      if (got !== want) begin
        miscmp++; $display("FAIL %s cyc t=%0d got %s want %s", tag, t, fmt(got), fmt(want));
      end
      if (done_a === 1'b1) begin
        n_done++;
        if (t_done < 0) t_done = t;
      end
      if (gate_we_a === 1'b1) begin
        n_gwe++;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          miscmp++; $display("FAIL %s extra_write got g=%0d j=%0d want none", tag, gate_a, unit_a);
        end else begin
          w = exp_q.pop_front();
          if ({gate_a, unit_a} !== w) begin
            miscmp++; $display("FAIL %s write_order got %h want %h", tag, {gate_a, unit_a}, w);
          end
        end
      end
      if (state_we_a === 1'b1) n_swe++;
    end
    start_a = 1'b0;
    vec_cnt++;
    if (t_done + 1 != 3*NA*p + 1) begin
      miscmp++; $display("FAIL %s done_cycle got %0d want %0d", tag, t_done + 1, 3*NA*p + 1);
    end
    vec_cnt++;
    if (n_done != 1) begin
      miscmp++; $display("FAIL %s done_count got %0d want 1", tag, n_done);
    end
    vec_cnt++;
    if (n_gwe != 3*NA) begin
      miscmp++; $display("FAIL %s gate_we_count got %0d want %0d", tag, n_gwe, 3*NA);
    end
    vec_cnt++;
    if (n_swe != NA) begin
      miscmp++; $display("FAIL %s state_we_count got %0d want %0d", tag, n_swe, NA);
    end
  endtask

  task automatic test_basic();
    test_timestep(0, 1'b0, "basic");
  endtask

  task automatic test_act_delay();
    test_timestep(4, 1'b0, "ack_delay4");
  endtask

  task automatic test_start_during_busy();
    test_timestep(int'($urandom_range(0, 3)), 1'b1, "start_busy");
  endtask

  // Run DUT A, assert abort during cycle t_abort, then expect idle and no more writes.
  task automatic run_abort(input int d, input int t_abort, input string tag);
    int d_eff, p, n_gwe, n_swe, n_done, exp_wr, exp_swe;
    obs_t got, want;
    d_eff = (d == 0) ? 1 : d;
    p = MA + NA + 2 + d_eff;
    n_gwe = 0; n_swe = 0; n_done = 0;
    ack_delay_a = d;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int t = 0; t <= t_abort; t++) begin
      if (t > 0) @(negedge clk);
      got = obs_a();
      want = model_at(t, MA, NA, 0, d_eff);
      vec_cnt++;
      if (got !== want) begin
        miscmp++; $display("FAIL %s cyc t=%0d got %s want %s", tag, t, fmt(got), fmt(want));
      end
      if (gate_we_a === 1'b1) n_gwe++;
      if (state_we_a === 1'b1) n_swe++;
      if (done_a === 1'b1) n_done++;
    end
    abort_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      abort_a = 1'b0;
      got = obs_a();
      vec_cnt++;
      if (got !== zero_o) begin
        miscmp++; $display("FAIL %s post_abort i=%0d got %s want all zero", tag, i, fmt(got));
      end
      if (gate_we_a === 1'b1) n_gwe++;
      if (state_we_a === 1'b1) n_swe++;
      if (done_a === 1'b1) n_done++;
    end
    exp_wr = (t_abort + 1) / p;
    exp_swe = (exp_wr > 2*NA) ? exp_wr - 2*NA : 0;
    vec_cnt++;
    if (n_gwe != exp_wr) begin
      miscmp++; $display("FAIL %s abort_writes got %0d want %0d", tag, n_gwe, exp_wr);
    end
    vec_cnt++;
    if (n_swe != exp_swe) begin
      miscmp++; $display("FAIL %s abort_state_we got %0d want %0d", tag, n_swe, exp_swe);
    end
    vec_cnt++;
    if (n_done != 0) begin
      miscmp++; $display("FAIL %s abort_done got %0d want 0", tag, n_done);
    end
  endtask

  task automatic test_abort();
    int p = MA + NA + 3;
    run_abort(0, (NA + 3)*p + MA + 1 + int'($urandom_range(0, NA - 1)), "abort_g1_j3");
    test_timestep(0, 1'b0, "after_abort");
  endtask

  task automatic test_abort_vs_ack();
    int p = MA + NA + 3;
    run_abort(0, int'($urandom_range(0, 3*NA - 1))*p + p - 2, "abort_vs_ack");
  endtask

  task automatic test_random_abort();
    for (int i = 0; i < 2; i++) begin
      int d = int'($urandom_range(0, 4));
      int p = MA + NA + 2 + ((d == 0) ? 1 : d);
      run_abort(d, int'($urandom_range(0, 3*NA*p - 1)), "abort_rand");
    end
  endtask

  task automatic test_reset_in_act();
    int p, n, t_r, n_swe;
    obs_t got, want;
    p = MA + NA + 2 + 3;
    n = 2*NA + int'($urandom_range(0, NA - 1));
    t_r = n*p + MA + NA + 2;
    n_swe = 0;
    ack_delay_a = 3;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int t = 0; t <= t_r; t++) begin
      if (t > 0) @(negedge clk);
      got = obs_a();
      want = model_at(t, MA, NA, 0, 3);
      vec_cnt++;
      if (got !== want) begin
        miscmp++; $display("FAIL rst_act cyc t=%0d got %s want %s", t, fmt(got), fmt(want));
      end
      if (state_we_a === 1'b1) n_swe++;
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (obs_a() !== zero_o) begin
      miscmp++; $display("FAIL rst_async got %s want all zero", fmt(obs_a()));
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (obs_a() !== zero_o) begin
        miscmp++; $display("FAIL rst_idle i=%0d got %s want all zero", i, fmt(obs_a()));
      end
      if (state_we_a === 1'b1) n_swe++;
    end
    vec_cnt++;
    if (n_swe != n - 2*NA) begin
      miscmp++; $display("FAIL rst_state_we got %0d want %0d", n_swe, n - 2*NA);
    end
  endtask

  task automatic test_wide_config();
    int p, tend, t_done, n_gwe, n_swe;
    obs_t got, want;
    p = MB + NB + 3;
    tend = 3*NB*p + 3;
    t_done = -1; n_gwe = 0; n_swe = 0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int t = 0; t <= tend; t++) begin
      if (t > 0) @(negedge clk);
      got = obs_b();
      want = model_at(t, MB, NB, 1, 1);
      vec_cnt++;
      if (got !== want) begin
        miscmp++; $display("FAIL wide cyc t=%0d got %s want %s", t, fmt(got), fmt(want));
      end
      if (t >= 1 && t <= 3) begin
        vec_cnt++;
        if (waddr_b !== WWB'(144*(t-1)) || mac_en_b !== 1'b1) begin
          miscmp++; $display("FAIL wide_waddr t=%0d got %0d want %0d", t, waddr_b, 144*(t-1));
        end
      end
      if (t == (NB + 5)*p) begin
        vec_cnt++;
        if (baddr_b !== BWB'(53) || mac_clr_b !== 1'b1) begin
          miscmp++; $display("FAIL wide_bias_g1_j5 got %0d clr=%0d want 53 clr=1", baddr_b, mac_clr_b);
        end
      end
      if (act_req_b === 1'b1 && gate_b === 2'd2) begin
        vec_cnt++;
        if (act_sel_b !== 2'd2) begin
          miscmp++; $display("FAIL wide_act_sel got %0d want 2", act_sel_b);
        end
      end
      if (done_b === 1'b1 && t_done < 0) t_done = t;
      if (gate_we_b === 1'b1) n_gwe++;
      if (state_we_b === 1'b1) n_swe++;
    end
    vec_cnt++;
    if (t_done + 1 != 3*NB*p + 1) begin
      miscmp++; $display("FAIL wide_done_cycle got %0d want %0d", t_done + 1, 3*NB*p + 1);
    end
    vec_cnt++;
    if (n_gwe != 3*NB || n_swe != NB) begin
      miscmp++; $display("FAIL wide_write_counts got %0d/%0d want %0d/%0d", n_gwe, n_swe, 3*NB, NB);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_act_delay();
    test_start_during_busy();
    test_abort();
    test_abort_vs_ack();
    test_random_abort();
    test_reset_in_act();
    test_wide_config();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/gru_sequencer.md
GRU_SEQUENCER -- requirements
Module: gru_sequencer

Interface
REQ-001 Parameter M_IN, default 24, input vector length (1..255).
REQ-002 Parameter N_UNITS, default 24, GRU units; stride = 3*N_UNITS.
REQ-003 Parameter ACT_H, default 0, candidate activation code: 0 = tanh, 1 = relu.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active low.
REQ-006 start  in  1  begin one timestep; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel of the running timestep.
REQ-008 busy  out  1  high from the cycle after start is accepted until DONE is left.
REQ-009 done  out  1  one-cycle pulse at timestep completion.
REQ-010 gate  out  2  current gate: 0 = z, 1 = r, 2 = h.
REQ-011 unit_idx  out  clog2(N_UNITS)  output neuron j.
REQ-012 k_idx  out  clog2(max(M_IN,N_UNITS))  operand index k.
REQ-013 bias_addr  out  clog2(3*N_UNITS)  equals gate*N_UNITS + j.
REQ-014 w_addr  out  clog2(3*N_UNITS*max(M_IN,N_UNITS))  equals k*stride + gate*N_UNITS + j.
REQ-015 mac_clr  out  1  load the accumulator with the bias word.
REQ-016 mac_en  out  1  accumulate one product.
REQ-017 mac_src  out  1  product source: 0 = input weights × input, 1 = recurrent weights × state.
REQ-018 rgate_mul  out  1  multiply the state operand by r[k]; high only in MAC_REC when gate = 2.
REQ-019 act_req / act_ack  out / in  1  activation handshake.
REQ-020 act_sel  out  2  activation select: 0 = sigmoid, 1 = tanh, 2 = relu.
REQ-021 gate_we  out  1  write the activated value into the z, r or candidate buffer [gate][j].
REQ-022 state_we  out  1  commit h[j] = z*h_old + (1 - z)*cand.

Function
REQ-023 FSM states: IDLE, BIAS, MAC_IN, MAC_REC, ACT, WRITE, DONE.
REQ-024 IDLE: when start = 1, load gate = 0 and j = 0, then go to BIAS.
REQ-025 BIAS: lasts 1 cycle with mac_clr = 1; the next state is MAC_IN with k = 0.
REQ-026 MAC_IN: lasts exactly M_IN cycles with mac_en = 1, mac_src = 0, and k running 0..M_IN-1.
REQ-027 MAC_REC: lasts exactly N_UNITS cycles with mac_en = 1, mac_src = 1, and k running 0..N_UNITS-1.
REQ-028 ACT: act_req is held high until act_ack is sampled high; the FSM leaves ACT on that edge and takes at least 1 cycle in ACT.
REQ-029 act_sel is 0 for gates 0 and 1; for gate 2 it is 1 when ACT_H = 0 and 2 when ACT_H = 1.
REQ-030 WRITE: lasts 1 cycle with gate_we = 1; state_we = 1 only when gate = 2.
REQ-031 After WRITE, j increments. At j = N_UNITS-1, j wraps to 0 and gate increments. After gate = 2 with j = N_UNITS-1, go to DONE.
REQ-032 DONE: lasts 1 cycle with done = 1, then return to IDLE.
REQ-033 Gate order z → r → h is mandatory, so all of r is written before any h accumulation.
REQ-034 start is ignored while busy = 1.
REQ-035 abort: from any non-IDLE state, go to IDLE on the next edge; no done pulse; no further writes after that edge.
REQ-036 If abort and act_ack are high in the same cycle, abort wins and no WRITE follows.
REQ-037 Cycles per neuron = M_IN + N_UNITS + 2 + (ACT cycles).
REQ-038 With immediate act_ack, done rises 3*N_UNITS*(M_IN+N_UNITS+3)+1 cycles after the start edge.
REQ-039 Addresses and indices are registered and valid in the same cycle as their strobe.
REQ-040 All strobes are 0 outside the states named above.

Reset
REQ-041 With rst_n low: state = IDLE, and every output, counter and index is 0.
REQ-042 Reset mid-timestep discards progress; buffers keep their old contents and no partial state_we is issued.

Structure
REQ-043 Shared package gru_ctrl_pkg holds the FSM state enum, the gate codes (Z/R/H), and the act_sel codes.
REQ-044 One sub-module, gru_addr_gen, combinationally computes bias_addr and w_addr from gate, j and k; the sequencer registers its outputs.

Verification
REQ-045 M_IN = N_UNITS = 24, ACT_H = 0, act_ack tied high, one start pulse → done at cycle 3673; 72 gate_we; 24 state_we; 0 extra pulses.
REQ-046 M_IN = 90, N_UNITS = 48, ACT_H = 1 → first MAC_IN w_addr sequence is 0, 144, 288, …; during gate 2, act_sel = 2; bias_addr for gate 1, j = 5 is 53.
REQ-047 act_ack delayed 4 cycles on each request → act_req holds for 4 cycles each time; total latency grows by 3*72 cycles; no duplicate gate_we.
REQ-048 start pulsed again during busy → ignored; exactly one done pulse.
REQ-049 abort asserted in MAC_REC of gate 1, j = 3 → IDLE next cycle; busy = 0; no done; no state_we; a fresh start then completes normally.
REQ-050 rst_n dropped in ACT of gate 2 → all outputs 0 asynchronously; after release, the block idles until start.
